// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation dispatcher.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [2:0] OP_0 = 3'd0;
    localparam logic [2:0] OP_1 = 3'd1;
    localparam logic [2:0] OP_2 = 3'd2;
    localparam logic [2:0] OP_3 = 3'd3;
    localparam logic [2:0] OP_4 = 3'd4;
    localparam logic [2:0] OP_5 = 3'd5;

    localparam int NUM_UNITS = 6;

    // Units 4 and 5 take several cycles and report completion through unit_done.
    localparam logic [5:0] MULTI_CYCLE_MASK = 6'b110000;

    localparam int TIMEOUT_DEFAULT = 64;

    // Codes 6 and 7 do not map to any unit.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_5);
    endfunction

endpackage

// File: rtl/alu_wait_ctr.sv
// Wait-cycle counter for multi-cycle units; tc flags the last allowed wait cycle.
module alu_wait_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // A TIMEOUT of 1 would give a zero-width counter, so keep at least one bit.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_dispatch.sv
// Accepts one ALU request at a time, starts the addressed unit, collects its
// result (or a timeout / illegal-op error) and holds it until consumed.
module alu_op_dispatch
    import alu_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [5:0]   unit_start,
    input  logic [5:0]   unit_done,
    output logic [2:0]   sel,
    input  logic [N-1:0] result_in,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_err
);

    state_e       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [2:0]   sel_q, sel_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_err_q, rsp_err_d;

    logic         ctr_clr;
    logic         ctr_en;
    logic         ctr_tc;

    logic [5:0]   op_onehot;
    logic         op_is_multi;
    logic         done_hit;

    // One-hot decode of the registered op; codes 6/7 decode to all zeros.
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_onehot
        assign op_onehot[gi] = (op_q == 3'(gi));
    end

    assign op_is_multi = |(op_onehot & MULTI_CYCLE_MASK);
    // Only the done bit of the active multi-cycle unit counts.
    assign done_hit    = |(op_onehot & MULTI_CYCLE_MASK & unit_done);

    alu_wait_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .tc    (ctr_tc)
    );

    // Next-state, operand/result capture and counter control.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (op_is_legal(req_op)) begin
                        // Select is set now so it already equals op during EXEC.
                        sel_d   = req_op;
                        state_d = ST_EXEC;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (op_is_multi) begin
                    ctr_clr = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    rsp_data_d = result_in;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_WAIT: begin
                ctr_en = 1'b1;
                // Done is checked first so it wins over a simultaneous timeout.
                if (done_hit) begin
                    rsp_data_d = result_in;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (ctr_tc) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign unit_start = (state_q == ST_EXEC) ? op_onehot : 6'b000000;
    assign sel        = sel_q;
    assign op_a       = a_q;
    assign op_b       = b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Directed bench for alu_op_dispatch with hand-computed expectations.
module tb_alu_op_dispatch;

    localparam int N  = 32;
    localparam int TO = 64;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [5:0]   unit_start;
    logic [5:0]   unit_done;
    logic [2:0]   sel;
    logic [N-1:0] result_in;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_dispatch #(
        .N       (N),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .op_a       (op_a),
        .op_b       (op_b),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .sel        (sel),
        .result_in  (result_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request; the next tick() is the accept edge.
    task automatic present(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
    endtask

    initial begin
        int n;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        unit_done = '0;
        result_in = '0;
        rsp_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_unit_start", 64'(unit_start), 64'd0);
        check_eq("rst_sel", 64'(sel), 64'd0);
        check_eq("rst_op_a", 64'(op_a), 64'd0);
        rst_n = 1'b1;
        $display("txn reset: initial state checked");

        // ---------------- op=2 single-cycle ----------------
        present(3'd2, 32'd5, 32'd3);
        result_in = 32'd8;
        tick();                                   // accept edge
        req_valid = 1'b0;
        check_eq("op2_start", 64'(unit_start), 64'b000100);
        check_eq("op2_sel", 64'(sel), 64'd2);
        check_eq("op2_op_a", 64'(op_a), 64'd5);
        check_eq("op2_op_b", 64'(op_b), 64'd3);
        check_eq("op2_valid_early", 64'(rsp_valid), 64'd0);
        check_eq("op2_ready_busy", 64'(req_ready), 64'd0);
        tick();
        check_eq("op2_start_once", 64'(unit_start), 64'd0);
        check_eq("op2_valid", 64'(rsp_valid), 64'd1);
        check_eq("op2_data", 64'(rsp_data), 64'd8);
        check_eq("op2_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("op2_valid_drop", 64'(rsp_valid), 64'd0);
        check_eq("op2_idle_ready", 64'(req_ready), 64'd1);
        check_eq("op2_op_a_hold", 64'(op_a), 64'd5);
        check_eq("op2_sel_hold", 64'(sel), 64'd2);
        $display("txn op=2 a=5 b=3 -> data=%0d err=%0d", rsp_data, rsp_err);

        // ---------------- op=7 illegal, back-pressured ----------------
        present(3'd7, 32'h11, 32'h22);
        result_in = 32'h5555_AAAA;
        tick();                                   // accept edge
        req_valid = 1'b0;
        check_eq("op7_valid", 64'(rsp_valid), 64'd1);
        check_eq("op7_err", 64'(rsp_err), 64'd1);
        check_eq("op7_data", 64'(rsp_data), 64'd0);
        check_eq("op7_no_start", 64'(unit_start), 64'd0);
        check_eq("op7_sel_hold", 64'(sel), 64'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("op7_hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("op7_hold_err", 64'(rsp_err), 64'd1);
            check_eq("op7_hold_data", 64'(rsp_data), 64'd0);
            check_eq("op7_hold_start", 64'(unit_start), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("op7_idle", 64'(req_ready), 64'd1);
        $display("txn op=7 -> err=%0d data=%0d", rsp_err, rsp_data);

        // ---------------- op=4 done after 10 cycles ----------------
        present(3'd4, 32'hA, 32'hB);
        result_in = 32'h0000_00F0;
        tick();                                   // accept edge, now EXEC
        req_valid = 1'b0;
        check_eq("op4_start", 64'(unit_start), 64'b010000);
        check_eq("op4_sel_exec", 64'(sel), 64'd4);
        tick();                                   // first WAIT cycle
        for (int i = 1; i < 10; i++) begin
            check_eq("op4_wait_sel", 64'(sel), 64'd4);
            check_eq("op4_wait_valid", 64'(rsp_valid), 64'd0);
            check_eq("op4_wait_start", 64'(unit_start), 64'd0);
            tick();
        end
        unit_done = 6'b010000;
        check_eq("op4_done_sel", 64'(sel), 64'd4);
        tick();
        unit_done = '0;
        check_eq("op4_valid", 64'(rsp_valid), 64'd1);
        check_eq("op4_data", 64'(rsp_data), 64'hF0);
        check_eq("op4_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        $display("txn op=4 done@10 -> data=0x%0h err=%0d", rsp_data, rsp_err);

        // ---------------- op=5 timeout with spurious done[4] ----------------
        present(3'd5, 32'h1, 32'h2);
        result_in = 32'hDEAD_BEEF;
        unit_done = 6'b010000;                    // ignored outside WAIT
        tick();                                   // accept edge
        req_valid = 1'b0;
        check_eq("op5_start", 64'(unit_start), 64'b100000);
        tick();                                   // first WAIT cycle
        n = 0;
        while (!rsp_valid && n < 4 * TO) begin
            unit_done = (n == 3 || n == 20) ? 6'b011111 : 6'b000000;
            tick();
            n++;
        end
        unit_done = '0;
        check_eq("op5_wait_cycles", 64'(n), 64'(TO));
        check_eq("op5_valid", 64'(rsp_valid), 64'd1);
        check_eq("op5_err", 64'(rsp_err), 64'd1);
        check_eq("op5_data", 64'(rsp_data), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        $display("txn op=5 timeout after %0d wait cycles -> err=%0d", n, rsp_err);

        // ---------------- done exactly on the timeout cycle ----------------
        present(3'd4, 32'h3, 32'h4);
        result_in = 32'h0000_ABCD;
        tick();                                   // accept edge
        req_valid = 1'b0;
        tick();                                   // WAIT, counter = 0
        for (int i = 0; i < TO - 1; i++) begin
            tick();
        end
        check_eq("race_valid_before", 64'(rsp_valid), 64'd0);
        unit_done = 6'b010000;                    // counter = TIMEOUT-1
        tick();
        unit_done = '0;
        check_eq("race_valid", 64'(rsp_valid), 64'd1);
        check_eq("race_err", 64'(rsp_err), 64'd0);
        check_eq("race_data", 64'(rsp_data), 64'hABCD);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        $display("txn op=4 done on timeout cycle -> data=0x%0h err=%0d", rsp_data, rsp_err);

        // ---------------- reset during WAIT, then op=1 ----------------
        present(3'd4, 32'h77, 32'h88);
        result_in = 32'h0;
        tick();                                   // accept edge
        req_valid = 1'b0;
        tick();                                   // WAIT
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 64'(req_ready), 64'd1);
        check_eq("arst_valid", 64'(rsp_valid), 64'd0);
        check_eq("arst_err", 64'(rsp_err), 64'd0);
        check_eq("arst_sel", 64'(sel), 64'd0);
        check_eq("arst_op_a", 64'(op_a), 64'd0);
        check_eq("arst_op_b", 64'(op_b), 64'd0);
        check_eq("arst_start", 64'(unit_start), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        unit_done = 6'b010000;                    // stale done must not revive op 4
        present(3'd1, 32'h9, 32'h6);
        result_in = 32'h0000_1234;
        tick();                                   // first edge after reset release
        req_valid = 1'b0;
        unit_done = '0;
        check_eq("post_rst_start", 64'(unit_start), 64'b000010);
        check_eq("post_rst_sel", 64'(sel), 64'd1);
        check_eq("post_rst_op_a", 64'(op_a), 64'h9);
        tick();
        check_eq("op1_valid", 64'(rsp_valid), 64'd1);
        check_eq("op1_data", 64'(rsp_data), 64'h1234);
        check_eq("op1_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("op1_idle", 64'(req_ready), 64'd1);
        $display("txn reset-in-wait then op=1 -> data=0x%0h err=%0d", rsp_data, rsp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
